mem_port_arbiter: RTL

- Shares one variable-latency unified memory port between the fetch requester (instruction reads) and the memory-stage requester (data loads/stores) of the pipelined core.
- Per requester: a req/done handshake. Toward memory: a single outstanding req/ack transaction.
- Data has priority over fetch, with a bounded-starvation guard so fetch always makes progress.
- Sits between the fetch/memory pipeline stages and the memory model, replacing their separate memory instances.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one variable-latency memory port between the fetch requester
//   (instruction reads) and the data requester (loads/stores). Data normally
//   wins. A streak counter makes sure a waiting fetch is granted after at most
//   MAX_DATA_STREAK consecutive data grants. Only one memory transaction is
//   outstanding at a time.
//
// Ports
//   clock, reset          : clock and asynchronous active-low reset
//   f_req/f_addr          : fetch request. f_done pulses with f_rdata valid
//   d_req/d_write/d_size/
//   d_addr/d_wdata        : data request. d_done pulses with d_rdata valid
//                           (d_rdata is updated by loads only)
//   m_req/m_write/m_size/
//   m_addr/m_wdata        : memory request, held until m_ack
//   m_ack/m_rdata         : memory completion pulse and read data
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_write,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_F} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t            state_q,   state_d;
    logic [3:0]        streak_q,  streak_d;
    logic              m_req_q,   m_req_d;
    logic              m_write_q, m_write_d;
    logic [1:0]        m_size_q,  m_size_d;
    logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              f_done_q,  f_done_d;
    logic              d_done_q,  d_done_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic fetch_starved;
    logic d_win;

    // Fetch is owed the next grant once data has won MAX_DATA_STREAK times
    // in a row while fetch was waiting.
    assign fetch_starved = f_req && (streak_q == STREAK_MAX);
    assign d_win         = d_req && !fetch_starved;

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        m_req_d   = m_req_q;
        m_write_d = m_write_q;
        m_size_d  = m_size_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        f_done_d  = 1'b0;
        d_done_d  = 1'b0;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                // Request fields are captured here and frozen until m_ack.
                if (d_win) begin
                    state_d   = GRANT_D;
                    m_req_d   = 1'b1;
                    m_write_d = d_write;
                    m_size_d  = d_size;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    // Only a data grant that makes fetch wait extends the streak.
                    if (!f_req)
                        streak_d = 4'd0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 4'd1;
                end else if (f_req) begin
                    state_d   = GRANT_F;
                    m_req_d   = 1'b1;
                    m_write_d = 1'b0;
                    m_size_d  = 2'd2;
                    m_addr_d  = f_addr;
                    m_wdata_d = '0;
                    streak_d  = 4'd0;
                end
            end
            GRANT_D: begin
                if (m_ack) begin
                    state_d  = IDLE;
                    m_req_d  = 1'b0;
                    d_done_d = 1'b1;
                    if (!m_write_q)
                        d_rdata_d = m_rdata;
                end
            end
            GRANT_F: begin
                if (m_ack) begin
                    state_d   = IDLE;
                    m_req_d   = 1'b0;
                    f_done_d  = 1'b1;
                    f_rdata_d = m_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            streak_q  <= 4'd0;
            m_req_q   <= 1'b0;
            m_write_q <= 1'b0;
            m_size_q  <= 2'd0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            f_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            m_req_q   <= m_req_d;
            m_write_q <= m_write_d;
            m_size_q  <= m_size_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            f_done_q  <= f_done_d;
            d_done_q  <= d_done_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_write = m_write_q;
    assign m_size  = m_size_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign f_done  = f_done_q;
    assign d_done  = d_done_q;
    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
